// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment display path: anode codes,
// segment patterns (active low, a..g), decode codes and decoder FSM states.
package ssd_pkg;

    localparam logic [3:0] AN_D0 = 4'b0111;
    localparam logic [3:0] AN_D1 = 4'b1011;
    localparam logic [3:0] AN_D2 = 4'b1101;
    localparam logic [3:0] AN_D3 = 4'b1110;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_P     = 7'b0011000;
    localparam logic [6:0] SEG_N     = 7'b0001001;
    localparam logic [6:0] SEG_L     = 7'b1110001;

    localparam logic [4:0] CODE_BLANK   = 5'h10;
    localparam logic [4:0] CODE_DASH    = 5'h11;
    localparam logic [4:0] CODE_P       = 5'h12;
    localparam logic [4:0] CODE_N       = 5'h13;
    localparam logic [4:0] CODE_L       = 5'h14;
    localparam logic [4:0] CODE_UNKNOWN = 5'h1F;

    typedef enum logic {
        HUNT,
        COLLECT
    } ssd_state_t;

    function automatic logic [3:0] an_of(input logic [1:0] idx);
        return ~(4'b1000 >> idx);
    endfunction

endpackage

// File: rtl/ssd_seg_decode.sv
// Maps one active-low segment pattern to its digit/symbol code.
module ssd_seg_decode
    import ssd_pkg::*;
(
    input  logic [6:0] seg,
    output logic [4:0] code
);

    always_comb begin
        code = CODE_UNKNOWN;
        case (seg)
            SEG_0:     code = 5'h00;
            SEG_1:     code = 5'h01;
            SEG_2:     code = 5'h02;
            SEG_3:     code = 5'h03;
            SEG_4:     code = 5'h04;
            SEG_5:     code = 5'h05;
            SEG_6:     code = 5'h06;
            SEG_7:     code = 5'h07;
            SEG_8:     code = 5'h08;
            SEG_9:     code = 5'h09;
            SEG_A:     code = 5'h0A;
            SEG_B:     code = 5'h0B;
            SEG_C:     code = 5'h0C;
            SEG_D:     code = 5'h0D;
            SEG_E:     code = 5'h0E;
            SEG_F:     code = 5'h0F;
            SEG_BLANK: code = CODE_BLANK;
            SEG_DASH:  code = CODE_DASH;
            SEG_P:     code = CODE_P;
            SEG_N:     code = CODE_N;
            SEG_L:     code = CODE_L;
            default:   code = CODE_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/ssd_frame_decoder.sv
// Samples the multiplexed anode/segment bus, rebuilds four-digit frames
// and reports a frame once it has repeated for STABLE_FRAMES scans.
module ssd_frame_decoder
    import ssd_pkg::*;
#(
    parameter int STABLE_FRAMES = 3,
    parameter int DWELL_MAX     = 1023,
    parameter int CNT_W         = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  an,
    input  logic [6:0]  seg,
    output logic [19:0] digits,
    output logic [27:0] raw_segs,
    output logic        frame_valid,
    output logic        stable,
    output logic        seq_error
);

    localparam int MW = $clog2(STABLE_FRAMES + 1);
    localparam logic [MW-1:0] M_MAX = MW'(STABLE_FRAMES);

    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    ssd_state_t       state, state_n;
    logic [1:0]       idx, idx_n, widx;
    logic [CNT_W-1:0] dwell, dwell_n;
    logic [27:0]      frame, frame_n;
    logic [27:0]      prev, prev_n;
    logic [MW-1:0]    mcnt, mcnt_n;
    logic             reported, reported_n;
    logic [19:0]      digits_n, dec;
    logic [27:0]      raw_n;
    logic             valid_n, stable_n, err_n;
    logic             same, nxt;

    for (genvar i = 0; i < 4; i++) begin : g_dec
        ssd_seg_decode u_dec (
            .seg  (frame[7*(3-i) +: 7]),
            .code (dec[5*(3-i) +: 5])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q        <= 4'b1111;
            seg_q       <= 7'h7F;
            state       <= HUNT;
            idx         <= '0;
            dwell       <= '0;
            frame       <= '1;
            prev        <= '0;
            mcnt        <= '0;
            reported    <= 1'b0;
            digits      <= '0;
            raw_segs    <= '1;
            frame_valid <= 1'b0;
            stable      <= 1'b0;
            seq_error   <= 1'b0;
        end else begin
            an_q        <= an;
            seg_q       <= seg;
            state       <= state_n;
            idx         <= idx_n;
            dwell       <= dwell_n;
            frame       <= frame_n;
            prev        <= prev_n;
            mcnt        <= mcnt_n;
            reported    <= reported_n;
            digits      <= digits_n;
            raw_segs    <= raw_n;
            frame_valid <= valid_n;
            stable      <= stable_n;
            seq_error   <= err_n;
        end
    end

    assign same = (an_q == an_of(idx));
    assign nxt  = (an_q == an_of(idx + 2'd1));

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        dwell_n    = dwell;
        frame_n    = frame;
        prev_n     = prev;
        mcnt_n     = mcnt;
        reported_n = reported;
        digits_n   = digits;
        raw_n      = raw_segs;
        valid_n    = 1'b0;
        stable_n   = stable;
        err_n      = 1'b0;
        widx       = idx;
        unique case (state)
            HUNT: begin
                if (an_q == AN_D0) begin
                    state_n        = COLLECT;
                    idx_n          = 2'd0;
                    dwell_n        = '0;
                    frame_n[27:21] = seg_q;
                end
            end
            COLLECT: begin
                if (dwell == CNT_W'(DWELL_MAX) || !(same || nxt)) begin
                    // errors win over a frame completing in the same cycle
                    err_n    = 1'b1;
                    mcnt_n   = '0;
                    stable_n = 1'b0;
                    state_n  = HUNT;
                end else if (same) begin
                    frame_n[7*(3-int'(idx)) +: 7] = seg_q;
                    dwell_n = dwell + CNT_W'(1);
                end else if (idx == 2'd3) begin
                    if (frame == prev) begin
                        mcnt_n = (mcnt == M_MAX) ? mcnt : mcnt + MW'(1);
                    end else begin
                        mcnt_n   = MW'(1);
                        stable_n = 1'b0;
                    end
                    if (mcnt_n == M_MAX) begin
                        stable_n = 1'b1;
                        if (!reported || frame != raw_segs) begin
                            digits_n   = dec;
                            raw_n      = frame;
                            valid_n    = 1'b1;
                            reported_n = 1'b1;
                        end
                    end
                    prev_n         = frame;
                    idx_n          = 2'd0;
                    dwell_n        = '0;
                    frame_n[27:21] = seg_q;
                end else begin
                    widx    = idx + 2'd1;
                    idx_n   = widx;
                    dwell_n = '0;
                    frame_n[7*(3-int'(widx)) +: 7] = seg_q;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_ssd_frame_decoder.sv
// Scoreboard bench: stimulus queues expected reports/errors, a monitor
// pops and compares whenever the decoder pulses frame_valid or seq_error.
module tb_ssd_frame_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [19:0] digits;
    logic [27:0] raw_segs;
    logic        frame_valid, stable, seq_error;

    typedef struct packed {
        logic        err;
        logic [19:0] d;
        logic [27:0] r;
    } ev_t;

    ev_t q[$];
    ev_t e_mon;
    int  tests = 0;
    int  fails = 0;

    localparam logic [27:0] F_1234 = {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
    localparam logic [19:0] D_1234 = {5'h01, 5'h02, 5'h03, 5'h04};
    localparam logic [27:0] F_OPEN = {7'b0000001, 7'b0011000, 7'b0110000, 7'b0001001};
    localparam logic [19:0] D_OPEN = {5'h00, 5'h12, 5'h0E, 5'h13};
    localparam logic [27:0] F_CLSD = {7'b0110001, 7'b1110001, 7'b0100100, 7'b1000010};
    localparam logic [19:0] D_CLSD = {5'h0C, 5'h14, 5'h05, 5'h0D};
    localparam logic [27:0] F_DASH = {7'b1111110, 7'b1111110, 7'b1111111, 7'b1111111};
    localparam logic [19:0] D_DASH = {5'h11, 5'h11, 5'h10, 5'h10};
    localparam logic [27:0] F_UNK  = {7'b1111110, 7'b1111110, 7'b1010101, 7'b1111111};
    localparam logic [19:0] D_UNK  = {5'h11, 5'h11, 5'h1F, 5'h10};

    ssd_frame_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .seg         (seg),
        .digits      (digits),
        .raw_segs    (raw_segs),
        .frame_valid (frame_valid),
        .stable      (stable),
        .seq_error   (seq_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_rep(input logic [19:0] d, input logic [27:0] r);
        ev_t e;
        e.err = 1'b0;
        e.d   = d;
        e.r   = r;
        q.push_back(e);
    endtask

    task automatic push_err();
        ev_t e;
        e     = '0;
        e.err = 1'b1;
        q.push_back(e);
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic dig(input logic [27:0] f, input int i);
        logic [3:0] a;
        a = ~(4'b1000 >> i);
        drive(a, f[7*(3-i) +: 7], 4);
    endtask

    task automatic scan(input logic [27:0] f);
        for (int i = 0; i < 4; i++) dig(f, i);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_frame_valid", 32'd1, 32'd0);
                end else begin
                    e_mon = q.pop_front();
                    check("event_kind_report", {31'd0, e_mon.err}, 32'd0);
                    check("digits", {12'd0, digits}, {12'd0, e_mon.d});
                    check("raw_segs", {4'd0, raw_segs}, {4'd0, e_mon.r});
                    check("stable_at_report", {31'd0, stable}, 32'd1);
                end
            end
            if (seq_error) begin
                if (q.size() == 0) begin
                    check("unexpected_seq_error", 32'd1, 32'd0);
                end else begin
                    e_mon = q.pop_front();
                    check("event_kind_error", {31'd0, e_mon.err}, 32'd1);
                    check("stable_at_error", {31'd0, stable}, 32'd0);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, {12'd0, digits}, 32'd0);
        check({tag, "_raw"}, {4'd0, raw_segs}, {4'd0, 28'hFFFFFFF});
        check({tag, "_fv"}, {31'd0, frame_valid}, 32'd0);
        check({tag, "_stable"}, {31'd0, stable}, 32'd0);
        check({tag, "_err"}, {31'd0, seq_error}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        an    = 4'b1111;
        seg   = 7'h7F;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic 1234 frame, reported at the first 0111 after scan 3
        push_rep(D_1234, F_1234);
        repeat (3) scan(F_1234);

        push_rep(D_OPEN, F_OPEN);
        dig(F_OPEN, 0);
        dig(F_OPEN, 1);
        check("stable_after_1234", {31'd0, stable}, 32'd1);
        dig(F_OPEN, 2);
        dig(F_OPEN, 3);
        dig(F_OPEN, 0);
        dig(F_OPEN, 1);
        check("stable_drop_open", {31'd0, stable}, 32'd0);
        check("digits_held", {12'd0, digits}, {12'd0, D_1234});
        dig(F_OPEN, 2);
        dig(F_OPEN, 3);
        scan(F_OPEN);

        push_rep(D_CLSD, F_CLSD);
        dig(F_CLSD, 0);
        dig(F_CLSD, 1);
        check("stable_after_open", {31'd0, stable}, 32'd1);
        dig(F_CLSD, 2);
        dig(F_CLSD, 3);
        dig(F_CLSD, 0);
        dig(F_CLSD, 1);
        check("stable_drop_clsd", {31'd0, stable}, 32'd0);
        dig(F_CLSD, 2);
        dig(F_CLSD, 3);
        scan(F_CLSD);

        // Out-of-order anode: 0111 -> 1101
        push_err();
        drive(4'b0111, 7'b0110001, 4);
        drive(4'b1101, 7'b0100100, 4);
        drive(4'b1011, 7'b1110001, 4);
        drive(4'b1110, 7'b1000010, 4);
        push_rep(D_1234, F_1234);
        repeat (3) scan(F_1234);

        // Anode stuck on digit1 past the dwell limit
        push_err();
        dig(F_1234, 0);
        drive(4'b1011, 7'b0010010, 1100);
        check("stable_after_dwell", {31'd0, stable}, 32'd0);

        push_rep(D_DASH, F_DASH);
        repeat (3) scan(F_DASH);
        push_rep(D_UNK, F_UNK);
        repeat (3) scan(F_UNK);

        // Reset in the middle of the second scan
        scan(F_1234);
        dig(F_1234, 0);
        dig(F_1234, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        dig(F_1234, 2);
        dig(F_1234, 3);
        push_rep(D_1234, F_1234);
        repeat (3) scan(F_1234);
        push_err();
        dig(F_1234, 0);
        drive(4'b1111, 7'h7F, 1);

        repeat (30) @(negedge clk);
        check("queue_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
